ppu_regfile: RTL and testbench
==============================

PPU_REGFILE -- requirements
Module: ppu_regfile

Interface
REQ-001 SHALL have parameter OAM_AW, default 8, meaning OAM address width; OAMADDR wraps modulo 2^OAM_AW.
REQ-002 SHALL have parameter VRAM_AW, default 14, meaning width of o_vram_addr, taken from v[VRAM_AW-1:0].
REQ-003 SHALL have parameter DECAY_CYCLES, default 1789773, meaning the open-bus decay period in i_cpu_clk cycles.
REQ-004 SHALL have port i_cpu_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port i_cpu_rstn, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have port i_bus_en, input, 1 bit: one-cycle access strobe; no register side effect occurs without it.
REQ-007 SHALL have port i_bus_addr, input, 16 bits: selects PPU when [15:13]==3'b001; register = [2:0].
REQ-008 SHALL have ports i_bus_wn (input, 1: 1=read, 0=write), i_bus_wdata (input, 8) and o_ppu_rdata (output, 8, combinational, 0 when not selected).
REQ-009 SHALL have ports o_oam_addr (output, OAM_AW), o_oam_we (output, 1), o_oam_wdata (output, 8) and i_oam_rdata (input, 8).
REQ-010 SHALL have ports o_vram_addr (output, VRAM_AW), o_vram_we (output, 1), o_vram_wdata (output, 8), i_vram_rdata (input, 8) and o_2007_visit (output, 1).
REQ-011 SHALL have ports o_ppuctrl (output, 8), o_ppumask (output, 8), o_scroll_t (output, 15: loopy t) and o_fine_x (output, 3).
REQ-012 SHALL have ports i_vblank_set (input, 1: set pulse), i_vblank_clr (input, 1: pre-render clear pulse), i_spr_ovfl (input, 1), i_spr_0hit (input, 1) and o_nmi_n (output, 1, active low).

Function
REQ-013 SHALL make every side effect below occur only when i_bus_en=1 and the PPU is selected; such an access is called "acc".
REQ-014 On an acc write to $2000, SHALL set ctrl<=d and t[11:10]<=d[1:0].
REQ-015 On an acc write to $2001, SHALL set mask<=d.
REQ-016 On an acc read of $2002, SHALL return {vbl_flag, i_spr_0hit, i_spr_ovfl, ob[4:0]}, then clear vbl_flag and w.
REQ-017 On an acc write to $2003, SHALL load oamaddr.
REQ-018 On an acc write to $2004, SHALL pulse o_oam_we and increment oamaddr (wrapping); an acc read SHALL return i_oam_rdata with no increment.
REQ-019 On an acc write to $2005 with w=0, SHALL set t[4:0]<=d[7:3], fine_x<=d[2:0] and w<=1.
REQ-020 On an acc write to $2005 with w=1, SHALL set t[9:5]<=d[7:3], t[14:12]<=d[2:0] and w<=0.
REQ-021 On an acc write to $2006 with w=0, SHALL set t[13:8]<=d[5:0], t[14]<=0 and w<=1.
REQ-022 On an acc write to $2006 with w=1, SHALL set t[7:0]<=d, v<=updated t (same edge) and w<=0.
REQ-023 On any acc to $2007, SHALL increment v by 32 if ctrl[2]=1, else by 1, modulo 2^15.
REQ-024 On an acc write to $2007, SHALL pulse o_vram_we; o_2007_visit SHALL be high combinationally for any acc to $2007.
REQ-025 On an acc read of $2007, SHALL return i_vram_rdata if v[13:8]==6'h3F, else rbuf; rbuf SHALL load i_vram_rdata on that edge.
REQ-026 SHALL set vbl_flag on i_vblank_set and clear it on i_vblank_clr; clear SHALL win over set.
REQ-027 If an acc read of $2002 coincides with i_vblank_set, the read SHALL return bit7=0 and the flag SHALL remain 0 (race suppression).
REQ-028 SHALL drive o_nmi_n = ~(vbl_flag & ctrl[7]); writing ctrl[7] 0->1 while vbl_flag=1 SHALL assert NMI the next cycle.
REQ-029 SHALL update open-bus latch ob on every acc write with d.
REQ-030 Writes to $2002 SHALL only update ob; reads of $2000, $2001, $2003, $2005 and $2006 SHALL return ob.

Reset
REQ-031 While i_cpu_rstn=0 at a clock edge, SHALL zero ctrl, mask, oamaddr, t, v, fine_x, w, rbuf, vbl_flag, ob and the decay counter.
REQ-032 Out of reset, o_nmi_n SHALL be 1 and o_oam_we, o_vram_we, o_ppuctrl, o_ppumask, o_scroll_t and o_fine_x SHALL be 0; a mid-sequence reset SHALL leave w=0.

Configuration
REQ-033 With PPU_OPENBUS_DECAY_EN defined, SHALL zero ob when a counter reaches DECAY_CYCLES-1 with no acc write; each acc write SHALL restart the counter.
REQ-034 Without PPU_OPENBUS_DECAY_EN, ob SHALL hold indefinitely and no counter logic SHALL exist.

Structure
REQ-035 SHALL take register index localparams (REG_CTRL..REG_DATA), PALETTE_PAGE (6'h3F) and the increment constants from shared package ppu_pkg.
REQ-036 SHALL contain exactly one sub-module, ppu_loopy_regs, holding t, v, fine_x and w.

Verification
REQ-037 Bench SHALL cover: write $2006=0x21 then 0x08 -> o_vram_addr=0x2108, w=0; with ctrl[2]=1, an acc to $2007 -> 0x2128.
REQ-038 Bench SHALL cover: write $2005=0x7D then 0x5E -> t[4:0]=0x0F, fine_x=5, t[9:5]=0x0B, t[14:12]=6.
REQ-039 Bench SHALL cover: v=0x2000 with VRAM returning 0xAA then 0xBB -> first $2007 read returns old rbuf, second returns 0xAA; at v=0x3F00, read returns the live value.
REQ-040 Bench SHALL cover: ctrl[7]=1 with i_vblank_set pulse -> o_nmi_n=0 next cycle; $2002 read returns bit7=1, then o_nmi_n=1.
REQ-041 Bench SHALL cover: $2002 read coinciding with i_vblank_set -> bit7=0 and no NMI; also oamaddr=0xFF, write $2004 -> oamaddr=0x00.
REQ-042 Bench SHALL cover: with PPU_OPENBUS_DECAY_EN and DECAY_CYCLES=16, write $2000=0x1F -> $2002[4:0]=0x1F, and 16 idle cycles later -> 0x00.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared register map and VRAM address step constants for the PPU register file.
// Latency: n/a (constants only). Backpressure: n/a.
package ppu_pkg;

  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_OAMADDR = 3'd3;
  localparam logic [2:0] REG_OAMDATA = 3'd4;
  localparam logic [2:0] REG_SCROLL  = 3'd5;
  localparam logic [2:0] REG_ADDR    = 3'd6;
  localparam logic [2:0] REG_DATA    = 3'd7;

  localparam logic [5:0] PALETTE_PAGE = 6'h3F;

  localparam logic [14:0] VINC_ACROSS = 15'd1;
  localparam logic [14:0] VINC_DOWN   = 15'd32;

  function automatic logic [14:0] vram_step(input logic inc_down);
    return inc_down ? VINC_DOWN : VINC_ACROSS;
  endfunction

endpackage

// File: rtl/ppu_loopy_regs.sv
// Scroll/address state (t, v, fine_x, shared write toggle w) driven by $2000/$2002/$2005/$2006/$2007.
// Latency: updates on the access edge. Backpressure: none, strobes are single-cycle.
module ppu_loopy_regs
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_ctrl,
  input  logic        clr_w,
  input  logic        wr_scroll,
  input  logic        wr_addr,
  input  logic        step,
  input  logic        inc_down,
  input  logic [7:0]  d,
  output logic [14:0] t,
  output logic [14:0] v,
  output logic [2:0]  fine_x,
  output logic        w
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      t      <= '0;
      v      <= '0;
      fine_x <= '0;
      w      <= 1'b0;
    end else begin
      if (wr_ctrl) t[11:10] <= d[1:0];
      if (clr_w) w <= 1'b0;
      if (wr_scroll) begin
        if (!w) begin
          t[4:0] <= d[7:3];
          fine_x <= d[2:0];
          w      <= 1'b1;
        end else begin
          t[9:5]   <= d[7:3];
          t[14:12] <= d[2:0];
          w        <= 1'b0;
        end
      end
      if (wr_addr) begin
        if (!w) begin
          t[13:8] <= d[5:0];
          t[14]   <= 1'b0;
          w       <= 1'b1;
        end else begin
          // v takes the fully assembled t on the same edge as the low byte lands
          t[7:0] <= d;
          v      <= {t[14:8], d};
          w      <= 1'b0;
        end
      end
      if (step) v <= v + vram_step(inc_down);
    end
  end

endmodule

// File: rtl/ppu_regfile.sv
// CPU-facing PPU register file ($2000-$2007) with OAM/VRAM ports, vblank flag, NMI and open-bus latch.
// Latency: reads combinational, state updates on the access edge; optional ob decay via PPU_OPENBUS_DECAY_EN. Backpressure: none.
module ppu_regfile
  import ppu_pkg::*;
#(
  parameter int OAM_AW       = 8,
  parameter int VRAM_AW      = 14,
  parameter int DECAY_CYCLES = 1789773
) (
  input  logic               i_cpu_clk,
  input  logic               i_cpu_rstn,
  input  logic               i_bus_en,
  input  logic [15:0]        i_bus_addr,
  input  logic               i_bus_wn,
  input  logic [7:0]         i_bus_wdata,
  output logic [7:0]         o_ppu_rdata,
  output logic [OAM_AW-1:0]  o_oam_addr,
  output logic               o_oam_we,
  output logic [7:0]         o_oam_wdata,
  input  logic [7:0]         i_oam_rdata,
  output logic [VRAM_AW-1:0] o_vram_addr,
  output logic               o_vram_we,
  output logic [7:0]         o_vram_wdata,
  input  logic [7:0]         i_vram_rdata,
  output logic               o_2007_visit,
  output logic [7:0]         o_ppuctrl,
  output logic [7:0]         o_ppumask,
  output logic [14:0]        o_scroll_t,
  output logic [2:0]         o_fine_x,
  input  logic               i_vblank_set,
  input  logic               i_vblank_clr,
  input  logic               i_spr_ovfl,
  input  logic               i_spr_0hit,
  output logic               o_nmi_n
);

  logic              sel, acc, rd, wr;
  logic [2:0]        ra;
  logic [7:0]        ctrl, mask, rbuf, ob;
  logic [OAM_AW-1:0] oamaddr;
  logic              vbl_flag;
  logic [14:0]       t, v;
  logic [2:0]        fine_x;
  logic              unused_bits;

  assign sel = (i_bus_addr[15:13] == 3'b001);
  assign acc = i_bus_en & sel;
  assign ra  = i_bus_addr[2:0];
  assign rd  = acc & i_bus_wn;
  assign wr  = acc & ~i_bus_wn;

  ppu_loopy_regs u_loopy (
    .clk       (i_cpu_clk),
    .rstn      (i_cpu_rstn),
    .wr_ctrl   (wr && (ra == REG_CTRL)),
    .clr_w     (rd && (ra == REG_STATUS)),
    .wr_scroll (wr && (ra == REG_SCROLL)),
    .wr_addr   (wr && (ra == REG_ADDR)),
    .step      (acc && (ra == REG_DATA)),
    .inc_down  (ctrl[2]),
    .d         (i_bus_wdata),
    .t         (t),
    .v         (v),
    .fine_x    (fine_x),
    .w         ()
  );

  always_ff @(posedge i_cpu_clk) begin
    if (!i_cpu_rstn) begin
      ctrl     <= '0;
      mask     <= '0;
      oamaddr  <= '0;
      rbuf     <= '0;
      vbl_flag <= 1'b0;
    end else begin
      if (wr && (ra == REG_CTRL)) ctrl <= i_bus_wdata;
      if (wr && (ra == REG_MASK)) mask <= i_bus_wdata;
      if (wr && (ra == REG_OAMADDR)) oamaddr <= OAM_AW'(i_bus_wdata);
      else if (wr && (ra == REG_OAMDATA)) oamaddr <= oamaddr + OAM_AW'(1);
      if (rd && (ra == REG_DATA)) rbuf <= i_vram_rdata;
      // A status read in the same cycle as the set pulse swallows the flag
      if (i_vblank_clr || (rd && (ra == REG_STATUS))) vbl_flag <= 1'b0;
      else if (i_vblank_set) vbl_flag <= 1'b1;
    end
  end

`ifdef PPU_OPENBUS_DECAY_EN
  localparam int DCW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  logic [DCW-1:0] decay_cnt;

  always_ff @(posedge i_cpu_clk) begin
    if (!i_cpu_rstn) begin
      ob        <= '0;
      decay_cnt <= '0;
    end else if (wr) begin
      ob        <= i_bus_wdata;
      decay_cnt <= '0;
    end else if (decay_cnt == DCW'(DECAY_CYCLES - 1)) begin
      ob        <= '0;
      decay_cnt <= '0;
    end else begin
      decay_cnt <= decay_cnt + DCW'(1);
    end
  end
`else
  always_ff @(posedge i_cpu_clk) begin
    if (!i_cpu_rstn) ob <= '0;
    else if (wr)     ob <= i_bus_wdata;
  end
`endif

  always_comb begin
    o_ppu_rdata = 8'h00;
    if (sel) begin
      o_ppu_rdata = ob;
      if (i_bus_wn) begin
        case (ra)
          REG_STATUS:  o_ppu_rdata = {vbl_flag, i_spr_0hit, i_spr_ovfl, ob[4:0]};
          REG_OAMDATA: o_ppu_rdata = i_oam_rdata;
          REG_DATA:    o_ppu_rdata = (v[13:8] == PALETTE_PAGE) ? i_vram_rdata : rbuf;
          default:     o_ppu_rdata = ob;
        endcase
      end
    end
  end

  assign o_oam_addr   = oamaddr;
  assign o_oam_we     = wr && (ra == REG_OAMDATA);
  assign o_oam_wdata  = i_bus_wdata;
  assign o_vram_addr  = v[VRAM_AW-1:0];
  assign o_vram_we    = wr && (ra == REG_DATA);
  assign o_vram_wdata = i_bus_wdata;
  assign o_2007_visit = acc && (ra == REG_DATA);
  assign o_ppuctrl    = ctrl;
  assign o_ppumask    = mask;
  assign o_scroll_t   = t;
  assign o_fine_x     = fine_x;
  assign o_nmi_n      = ~(vbl_flag & ctrl[7]);

  assign unused_bits = ^{i_bus_addr[12:3], v};

endmodule

// File: tb/tb_ppu_regfile.sv
// Directed bench for ppu_regfile: stimulus queues expected values, a negedge monitor pops and checks.
module tb_ppu_regfile;

  localparam int K_RDATA   = 0;
  localparam int K_NMI     = 1;
  localparam int K_CTRL    = 2;
  localparam int K_MASK    = 3;
  localparam int K_T       = 4;
  localparam int K_FINEX   = 5;
  localparam int K_VADDR   = 6;
  localparam int K_OAMADDR = 7;
  localparam int K_OAMWE   = 8;
  localparam int K_VRAMWE  = 9;
  localparam int K_W       = 10;
  localparam int K_VISIT   = 11;
  localparam int K_OAMWD   = 12;
  localparam int K_VRAMWD  = 13;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        bus_en = 1'b0;
  logic [15:0] bus_addr = 16'h0000;
  logic        bus_wn = 1'b0;
  logic [7:0]  bus_wdata = 8'h00;
  logic [7:0]  oam_rdata = 8'h00;
  logic [7:0]  vram_rdata = 8'h00;
  logic        vblank_set = 1'b0;
  logic        vblank_clr = 1'b0;
  logic        spr_ovfl = 1'b0;
  logic        spr_0hit = 1'b0;
  logic        probe_vld = 1'b0;

  logic [7:0]  ppu_rdata;
  logic [7:0]  oam_addr;
  logic        oam_we;
  logic [7:0]  oam_wdata;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic        visit;
  logic [7:0]  ppuctrl;
  logic [7:0]  ppumask;
  logic [14:0] scroll_t;
  logic [2:0]  fine_x;
  logic        nmi_n;

  always #5 clk = ~clk;

  ppu_regfile #(.OAM_AW(8), .VRAM_AW(14), .DECAY_CYCLES(16)) dut (
    .i_cpu_clk    (clk),
    .i_cpu_rstn   (rstn),
    .i_bus_en     (bus_en),
    .i_bus_addr   (bus_addr),
    .i_bus_wn     (bus_wn),
    .i_bus_wdata  (bus_wdata),
    .o_ppu_rdata  (ppu_rdata),
    .o_oam_addr   (oam_addr),
    .o_oam_we     (oam_we),
    .o_oam_wdata  (oam_wdata),
    .i_oam_rdata  (oam_rdata),
    .o_vram_addr  (vram_addr),
    .o_vram_we    (vram_we),
    .o_vram_wdata (vram_wdata),
    .i_vram_rdata (vram_rdata),
    .o_2007_visit (visit),
    .o_ppuctrl    (ppuctrl),
    .o_ppumask    (ppumask),
    .o_scroll_t   (scroll_t),
    .o_fine_x     (fine_x),
    .i_vblank_set (vblank_set),
    .i_vblank_clr (vblank_clr),
    .i_spr_ovfl   (spr_ovfl),
    .i_spr_0hit   (spr_0hit),
    .o_nmi_n      (nmi_n)
  );

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_RDATA:   return {24'd0, ppu_rdata};
      K_NMI:     return {31'd0, nmi_n};
      K_CTRL:    return {24'd0, ppuctrl};
      K_MASK:    return {24'd0, ppumask};
      K_T:       return {17'd0, scroll_t};
      K_FINEX:   return {29'd0, fine_x};
      K_VADDR:   return {18'd0, vram_addr};
      K_OAMADDR: return {24'd0, oam_addr};
      K_OAMWE:   return {31'd0, oam_we};
      K_VRAMWE:  return {31'd0, vram_we};
      K_W:       return {31'd0, dut.u_loopy.w};
      K_VISIT:   return {31'd0, visit};
      K_OAMWD:   return {24'd0, oam_wdata};
      K_VRAMWD:  return {24'd0, vram_wdata};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check_one();
    exp_t        e;
    logic [31:0] act;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_underflow: got an output with no expected entry at %0t", $time);
    end else begin
      e   = sbq.pop_front();
      act = observe(e.kind);
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
      end
    end
  endtask

  // Reads of a selected register come first, then any explicit probe in the same cycle
  always @(negedge clk) begin
    if (bus_en && bus_wn && (bus_addr[15:13] == 3'b001)) check_one();
    if (probe_vld) check_one();
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [31:0] e, input string n);
    exp_t x;
    x.kind = k;
    x.exp  = e;
    x.name = n;
    sbq.push_back(x);
  endtask

  task automatic probe(input int k, input logic [31:0] e, input string n);
    push(k, e, n);
    probe_vld = 1'b1;
    cyc();
    probe_vld = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus_en    = 1'b1;
    bus_wn    = 1'b0;
    bus_addr  = 16'h2000 | {13'd0, a};
    bus_wdata = d;
    cyc();
    bus_en = 1'b0;
  endtask

  task automatic wr_chk(input logic [2:0] a, input logic [7:0] d, input int k, input logic [31:0] e,
                        input string n);
    push(k, e, n);
    probe_vld = 1'b1;
    wr(a, d);
    probe_vld = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string n);
    push(K_RDATA, {24'd0, e}, n);
    bus_en   = 1'b1;
    bus_wn   = 1'b1;
    bus_addr = 16'h2000 | {13'd0, a};
    cyc();
    bus_en = 1'b0;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [7:0] e, input string n,
                        input int k, input logic [31:0] pe, input string pn);
    push(K_RDATA, {24'd0, e}, n);
    push(k, pe, pn);
    probe_vld = 1'b1;
    bus_en    = 1'b1;
    bus_wn    = 1'b1;
    bus_addr  = 16'h2000 | {13'd0, a};
    cyc();
    bus_en    = 1'b0;
    probe_vld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    repeat (3) cyc();
    rstn = 1'b1;

    // reset state
    probe(K_NMI, 1, "rst_nmi_n");
    probe(K_CTRL, 0, "rst_ctrl");
    probe(K_MASK, 0, "rst_mask");
    probe(K_T, 0, "rst_t");
    probe(K_FINEX, 0, "rst_fine_x");
    probe(K_VADDR, 0, "rst_vram_addr");
    probe(K_OAMADDR, 0, "rst_oam_addr");
    probe(K_OAMWE, 0, "rst_oam_we");
    probe(K_VRAMWE, 0, "rst_vram_we");
    probe(K_W, 0, "rst_w");

    // unselected address reads as zero
    bus_en = 1'b1; bus_wn = 1'b1; bus_addr = 16'h4002;
    probe(K_RDATA, 0, "unselected_rdata");
    bus_en = 1'b0;

    // $2006 address load and $2007 increment by 32
    wr(3'd6, 8'h21);
    probe(K_W, 1, "w_after_2006_hi");
    wr(3'd6, 8'h08);
    probe(K_VADDR, 32'h2108, "vaddr_2108");
    probe(K_W, 0, "w_after_2006_lo");
    wr(3'd0, 8'h04);
    probe(K_CTRL, 32'h04, "ctrl_04");
    wr_chk(3'd7, 8'h55, K_VRAMWE, 1, "vram_we_pulse");
    probe(K_VRAMWD, 32'h55, "vram_wdata");
    probe(K_VADDR, 32'h2128, "vaddr_inc32");
    probe(K_VRAMWE, 0, "vram_we_idle");

    // $2005 scroll pair
    wr(3'd5, 8'h7D);
    probe(K_T, 32'h210F, "t_scroll_x");
    probe(K_FINEX, 5, "fine_x_5");
    wr(3'd5, 8'h5E);
    probe(K_T, 32'h616F, "t_scroll_y");
    probe(K_FINEX, 5, "fine_x_hold");
    probe(K_W, 0, "w_after_2005_pair");

    // buffered $2007 reads and live palette read
    wr(3'd6, 8'h20);
    wr(3'd6, 8'h00);
    probe(K_VADDR, 32'h2000, "vaddr_2000");
    vram_rdata = 8'hAA;
    rd_chk(3'd7, 8'h00, "rd2007_old_rbuf", K_VISIT, 1, "visit_on_read");
    vram_rdata = 8'hBB;
    rd(3'd7, 8'hAA, "rd2007_buffered");
    probe(K_VADDR, 32'h2040, "vaddr_after_reads");
    probe(K_VISIT, 0, "visit_idle");
    wr(3'd6, 8'h3F);
    wr(3'd6, 8'h00);
    vram_rdata = 8'hCC;
    rd(3'd7, 8'hCC, "rd2007_palette_live");
    probe(K_VADDR, 32'h3F20, "vaddr_palette_inc");

    // vblank flag and NMI
    wr(3'd0, 8'h00);
    vblank_set = 1'b1; cyc(); vblank_set = 1'b0;
    probe(K_NMI, 1, "nmi_masked_by_ctrl");
    wr(3'd0, 8'h80);
    probe(K_NMI, 0, "nmi_on_ctrl7_rise");
    spr_0hit = 1'b1;
    rd(3'd2, 8'hC0, "status_vbl_set");
    spr_0hit = 1'b0;
    probe(K_NMI, 1, "nmi_after_status_rd");
    vblank_set = 1'b1; cyc(); vblank_set = 1'b0;
    probe(K_NMI, 0, "nmi_on_vblank_set");
    vblank_clr = 1'b1; cyc(); vblank_clr = 1'b0;
    probe(K_NMI, 1, "nmi_after_vblank_clr");
    vblank_set = 1'b1; vblank_clr = 1'b1; cyc(); vblank_set = 1'b0; vblank_clr = 1'b0;
    probe(K_NMI, 1, "clr_wins_over_set");

    // status read racing the set pulse
    vblank_set = 1'b1;
    rd(3'd2, 8'h00, "status_race_bit7");
    vblank_set = 1'b0;
    probe(K_NMI, 1, "race_no_nmi");
    rd(3'd2, 8'h00, "race_flag_stays_0");

    // OAM address wrap and OAM data read
    wr(3'd3, 8'hFF);
    probe(K_OAMADDR, 32'hFF, "oamaddr_ff");
    wr_chk(3'd4, 8'h12, K_OAMWE, 1, "oam_we_pulse");
    probe(K_OAMWD, 32'h12, "oam_wdata");
    probe(K_OAMADDR, 32'h00, "oamaddr_wrap");
    oam_rdata = 8'h77;
    rd(3'd4, 8'h77, "oam_data_read");
    probe(K_OAMADDR, 32'h00, "oam_read_no_inc");

    // open-bus latch
    wr(3'd1, 8'h1E);
    probe(K_MASK, 32'h1E, "mask_1e");
    rd(3'd1, 8'h1E, "ob_rd_2001");
    rd(3'd0, 8'h1E, "ob_rd_2000");
    wr(3'd2, 8'h35);
    probe(K_CTRL, 32'h80, "status_wr_ctrl_unchanged");
    rd(3'd5, 8'h35, "ob_rd_2005");
    rd(3'd6, 8'h35, "ob_rd_2006");
    rd(3'd3, 8'h35, "ob_rd_2003");

    // open-bus decay (or hold when decay is not built)
    wr(3'd0, 8'h1F);
    rd(3'd2, 8'h1F, "status_ob_fresh");
    spr_ovfl = 1'b1;
    rd(3'd2, 8'h3F, "status_ovfl");
    spr_ovfl = 1'b0;
    repeat (20) cyc();
`ifdef PPU_OPENBUS_DECAY_EN
    rd(3'd2, 8'h00, "ob_decayed");
`else
    rd(3'd2, 8'h1F, "ob_held");
`endif

    // reset in the middle of a write pair
    wr(3'd5, 8'h10);
    probe(K_W, 1, "w_before_reset");
    rstn = 1'b0; cyc(); rstn = 1'b1;
    probe(K_W, 0, "w_after_mid_reset");
    probe(K_T, 0, "t_after_mid_reset");
    probe(K_CTRL, 0, "ctrl_after_mid_reset");
    probe(K_NMI, 1, "nmi_after_mid_reset");
    wr(3'd6, 8'h21);
    wr(3'd6, 8'h08);
    probe(K_VADDR, 32'h2108, "addr_pair_after_reset");

    repeat (3) cyc();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
